// File: rtl/prim_encoder_64to6_seq.sv
// Sequential 64-to-6 encoder: emits the index of every set request bit, lowest first,
// one per valid/ready handshake. Optional remaining-count port via PRIM_ENC_REMAIN_CNT_EN.
module prim_encoder_64to6_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_vec_valid,
  input  logic [63:0] i_vec,
  output logic        o_vec_ready,
  output logic        o_idx_valid,
  output logic [5:0]  o_idx,
  input  logic        i_idx_ready,
  output logic        o_last,
  output logic        o_busy
`ifdef PRIM_ENC_REMAIN_CNT_EN
  ,
  output logic [6:0]  o_remain
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pending_q, pending_d;
  logic [5:0]  low_idx;
  logic        single;
  logic        emit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Highest-to-lowest scan so the lowest set bit wins.
  always_comb begin
    low_idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (pending_q[i]) low_idx = 6'(i);
    end
  end

  assign single = (pending_q != 64'd0) && ((pending_q & (pending_q - 64'd1)) == 64'd0);
  assign emit   = (state_q == ST_EMIT);

  assign o_vec_ready = !emit;
  assign o_busy      = emit;
  assign o_idx_valid = emit;
  assign o_idx       = emit ? low_idx : 6'd0;
  assign o_last      = emit & single;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (i_flush) begin
      state_d   = ST_IDLE;
      pending_d = 64'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_vec_valid && (i_vec != 64'd0)) begin
            pending_d = i_vec;
            state_d   = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (i_idx_ready) begin
            pending_d = pending_q & (pending_q - 64'd1);
            if (single) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef PRIM_ENC_REMAIN_CNT_EN
  logic [6:0] remain_q, remain_d;
  logic [6:0] vec_pop;

  always_comb begin
    vec_pop = 7'd0;
    for (int i = 0; i < 64; i++) vec_pop = vec_pop + 7'(i_vec[i]);
  end

  always_comb begin
    remain_d = remain_q;
    if (i_flush) begin
      remain_d = 7'd0;
    end else if (!emit) begin
      if (i_vec_valid && (i_vec != 64'd0)) remain_d = vec_pop;
    end else if (i_idx_ready) begin
      remain_d = remain_q - 7'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) remain_q <= 7'd0;
    else          remain_q <= remain_d;
  end

  assign o_remain = remain_q;
`endif

endmodule

// File: tb/tb_prim_encoder_64to6_seq.sv
// Directed bench for prim_encoder_64to6_seq: scoreboard of expected indices filled at load,
// drained against the index handshake stream.
module tb_prim_encoder_64to6_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_vec_valid;
  logic [63:0] i_vec;
  logic        o_vec_ready;
  logic        o_idx_valid;
  logic [5:0]  o_idx;
  logic        i_idx_ready;
  logic        o_last;
  logic        o_busy;
`ifdef PRIM_ENC_REMAIN_CNT_EN
  logic [6:0]  o_remain;
`endif

  prim_encoder_64to6_seq dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_vec_valid (i_vec_valid),
    .i_vec       (i_vec),
    .o_vec_ready (o_vec_ready),
    .o_idx_valid (o_idx_valid),
    .o_idx       (o_idx),
    .i_idx_ready (i_idx_ready),
    .o_last      (o_last),
    .o_busy      (o_busy)
`ifdef PRIM_ENC_REMAIN_CNT_EN
    ,
    .o_remain    (o_remain)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       last;
    logic [5:0] idx;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [63:0] v);
    int hi;
    hi = -1;
    for (int i = 0; i < 64; i++) if (v[i]) hi = i;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) sb.push_back('{last: (i == hi), idx: 6'(i)});
    end
    chk("vec_ready_at_load", o_vec_ready, 1'b1);
    i_vec_valid = 1'b1;
    i_vec       = v;
    tick();
    i_vec_valid = 1'b0;
    i_vec       = 64'd0;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   budget;
    budget = sb.size();
    i_idx_ready = 1'b1;
    for (int n = 0; n < budget; n++) begin
      chk({tag, "_valid"}, o_idx_valid, 1'b1);
`ifdef PRIM_ENC_REMAIN_CNT_EN
      chk({tag, "_remain"}, o_remain, 64'(sb.size()));
`endif
      e = sb.pop_front();
      chk({tag, "_idx"}, o_idx, e.idx);
      chk({tag, "_last"}, o_last, e.last);
      tick();
    end
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_done_valid"}, o_idx_valid, 1'b0);
    chk({tag, "_done_ready"}, o_vec_ready, 1'b1);
`ifdef PRIM_ENC_REMAIN_CNT_EN
    chk({tag, "_done_remain"}, o_remain, 0);
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, o_vec_ready, 1'b1);
    chk({tag, "_valid"}, o_idx_valid, 1'b0);
    chk({tag, "_idx"}, o_idx, 6'd0);
    chk({tag, "_last"}, o_last, 1'b0);
    chk({tag, "_busy"}, o_busy, 1'b0);
`ifdef PRIM_ENC_REMAIN_CNT_EN
    chk({tag, "_remain"}, o_remain, 0);
`endif
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_flush     = 1'b0;
    i_vec_valid = 1'b0;
    i_vec       = 64'd0;
    i_idx_ready = 1'b0;

    // Reset held for 3 cycles, then released.
    #1;
    for (int c = 0; c < 3; c++) begin
      chk_idle("reset");
      tick();
    end
    i_rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    // Multi-bit vector at full throughput.
    i_idx_ready = 1'b1;
    load(64'h8000_0000_0001_0005);
    drain("multi");

    // Backpressure: index held for 5 cycles.
    i_idx_ready = 1'b0;
    load(64'h0000_0000_0000_0110);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", o_idx_valid, 1'b1);
      chk("bp_idx", o_idx, 6'd4);
      chk("bp_last", o_last, 1'b0);
      chk("bp_busy", o_busy, 1'b1);
      chk("bp_ready", o_vec_ready, 1'b0);
      tick();
    end
    drain("bp");

    // Zero vector is swallowed.
    load(64'h0);
    chk_idle("zero");

    // Full vector: 64 indices in order.
    load({64{1'b1}});
    drain("full");

    // Flush after one index.
    load(64'hF0);
    i_idx_ready = 1'b1;
    chk("flush_first_idx", o_idx, 6'd4);
    void'(sb.pop_front());
    tick();
    i_idx_ready = 1'b0;
    chk("flush_pre_idx", o_idx, 6'd5);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    sb.delete();
    chk_idle("flush");
    i_idx_ready = 1'b1;
    load(64'h2);
    drain("after_flush");

    // Asynchronous reset in the middle of a cycle during EMIT.
    load(64'hFF00);
    chk("ar_first_idx", o_idx, 6'd8);
    void'(sb.pop_front());
    tick();
    chk("ar_pre_valid", o_idx_valid, 1'b1);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    sb.delete();
    tick();
    i_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_idle("no_stale");
    end
    load(64'h1);
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prim_encoder_64to6_seq.md
# prim_encoder_64to6_seq

Sequential 64-to-6 request encoder: accepts a 64-bit request vector and emits the 6-bit binary index of every set bit, lowest index first, one per valid/ready handshake. It is the encode-side counterpart of the 6-to-64 decoder primitive: a decoded or one-hot/multi-hot vector goes in and binary indices come out. It sits in the primitive cell library and serves arbiters, interrupt/pending-bit scanners and free-list allocators.

## Interface

Parameters: none; widths are fixed at 64 in, 6 out.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_flush`  in  1  synchronous abort; drops all pending bits.
- `i_vec_valid`  in  1  request vector offered.
- `i_vec`  in  64  request vector; bit k set means index k is pending.
- `o_vec_ready`  out  1  block accepts a vector this cycle.
- `o_idx_valid`  out  1  `o_idx` holds a pending index.
- `o_idx`  out  6  binary index of the lowest pending bit.
- `i_idx_ready`  in  1  consumer takes `o_idx` this cycle.
- `o_last`  out  1  `o_idx` is the final pending index of the current vector.
- `o_busy`  out  1  block is in EMIT.
- `o_remain`  out  7  number of pending bits, 0..64. Present only with `PRIM_ENC_REMAIN_CNT_EN`.

## Operation

Internal state is a 64-bit `pending` register and a 2-state FSM.

**IDLE**
- `o_vec_ready`=1.
- A vector handshake (`i_vec_valid` & `o_vec_ready`) with `i_vec`≠0 loads `pending`←`i_vec`, and the FSM moves to EMIT.
- A handshake with `i_vec`==0 is accepted and discarded. The FSM stays in IDLE and no index is produced.

**EMIT**
- `o_vec_ready`=0 and `o_busy`=1.
- `o_idx_valid`=1.
- `o_idx` = position of the lowest set bit of `pending`.
- `o_last`=1 iff exactly one bit of `pending` is set.
- An index handshake (`o_idx_valid` & `i_idx_ready`) clears that bit in `pending`. If `o_last` was 1, the FSM moves to IDLE.
- While `i_idx_ready`=0, `pending`, `o_idx` and `o_last` are held stable.

**Common rules**
- `i_flush`=1 in any state: `pending`←0 and FSM←IDLE at the next edge. Flush overrides a simultaneous vector or index handshake. The index presented in the flush cycle still counts as transferred if `i_idx_ready`=1; the consumer must ignore it if required.
- When `o_idx_valid`=0, `o_idx`=0 and `o_last`=0.
- All outputs are derived from registered state only; there is no combinational path from any input to any output.

**Reset value of every output** (while `i_rst_n`=0 and until the first accepted vector):
- `o_vec_ready`=1
- `o_idx_valid`=0
- `o_idx`=0
- `o_last`=0
- `o_busy`=0
- `o_remain`=0

Asserting reset mid-EMIT drops all pending bits immediately (asynchronously).

## Timing

- **Latency:** vector accepted at edge N; first index valid in the cycle after edge N.
- **Throughput:** one index per cycle while `i_idx_ready`=1. A vector with k set bits finishes in k cycles.
- **Turnaround:** `o_vec_ready` rises in the cycle after the final index handshake. The minimum gap between the last index of one vector and the first index of the next is 2 cycles.
- **Full vector:** `i_vec`=all ones takes exactly 64 index cycles, with indices 0..63 in order.

## Configuration

`PRIM_ENC_REMAIN_CNT_EN`
- **Defined:**
  - Adds the `o_remain` port and a 7-bit counter.
  - On load, the counter takes the population count of `i_vec`.
  - It decrements by 1 on each index handshake.
  - It clears to 0 on flush or reset.
  - `o_remain` always equals popcount(`pending`).
- **Undefined:** the port and counter do not exist. All other behaviour is identical.

## Test plan

- **Reset:** hold `i_rst_n`=0 for 3 cycles, then release. Required: `o_vec_ready`=1, `o_idx_valid`=0, `o_idx`=0, `o_busy`=0 throughout.
- **Multi-bit vector:** load `i_vec`=64'h8000_0000_0001_0005 with `i_idx_ready`=1. Required indices on consecutive cycles: 0, 2, 16, 63, with `o_last`=1 only on 63. `o_vec_ready` returns to 1 one cycle later. `o_remain` (if enabled) reads 4, 3, 2, 1, then 0.
- **Backpressure:** load 64'h0000_0000_0000_0110 and hold `i_idx_ready`=0 for 5 cycles. Required: `o_idx`=4 held stable and `o_last`=0. After releasing `i_idx_ready`, the block emits 4 then 8.
- **Zero vector and full vector:** loading 64'h0 leaves `o_idx_valid`=0 and the FSM in IDLE. Loading all ones yields 64 consecutive indices 0..63, with `o_last` set only on 63.
- **Flush mid-stream:** load 64'hF0, take one index (4), then pulse `i_flush`. Required: `o_idx_valid`=0 and `o_vec_ready`=1 the next cycle. A subsequent vector 64'h2 yields index 1 only.
- **Asynchronous reset mid-EMIT:** while emitting from 64'hFF00, drop `i_rst_n` between clock edges. Required: `o_idx_valid`=0 immediately, without waiting for a clock edge, and no stale index is emitted after release.
